// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file: parameterised register file with one write port and two read ports.
//
// Parameters
//   WIDTH    data width of every register and data port
//   DEPTH    number of registers (2..256)
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//   REG_OUT  0: combinational read; 1: registered read, 1-cycle latency
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   we/waddr/wdata   write port
//   rd_en            read request qualifier for both read ports
//   raddr0/raddr1    read addresses
//   rdata0/rdata1    read data
//   rvalid           rdata0/rdata1 hold data for an accepted rd_en
//   wr_err           one-cycle pulse: a write was dropped (waddr >= DEPTH)
//
// Handshake: there is no back-pressure. A read is accepted on every edge
// where rd_en=1; rvalid marks the cycle(s) in which rdataN carry that result
// (same cycle when REG_OUT=0, next cycle only when REG_OUT=1).
// ----------------------------------------------------------------------------
module reg_file #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int REG_OUT  = 0,
    localparam int ADDR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid,
    output logic              wr_err
);

    // One extra bit so DEPTH itself (e.g. 256) is representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic              wr_err_q;
    logic              wr_err_d;
    logic              wr_in_range;
    logic              wr_zero_blocked;
    logic              wr_legal;
    logic [ADDR_W-1:0] raddr_a [2];
    logic [WIDTH-1:0]  rd_comb [2];

    assign wr_in_range     = ({1'b0, waddr} < DEPTH_EXT);
    assign wr_zero_blocked = (ZERO_REG != 0) && (waddr == '0);
    assign wr_legal        = we && wr_in_range && !wr_zero_blocked;
    // Only out-of-range writes are errors; a write to a hardwired zero
    // register is silently ignored.
    assign wr_err_d        = we && !wr_in_range;

    assign raddr_a[0] = raddr0;
    assign raddr_a[1] = raddr1;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_legal) begin
            regs_d[waddr] = wdata;
        end
    end

    // Read path: out-of-range and hardwired-zero addresses return 0; a legal
    // write to the same address in this cycle is forwarded.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_comb[p] = '0;
            if (({1'b0, raddr_a[p]} < DEPTH_EXT) &&
                !((ZERO_REG != 0) && (raddr_a[p] == '0))) begin
                if (wr_legal && (raddr_a[p] == waddr)) begin
                    rd_comb[p] = wdata;
                end else begin
                    rd_comb[p] = regs_q[raddr_a[p]];
                end
            end
        end
    end

    // Reset has priority, so a write on the edge that coincides with reset
    // never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] rdata0_q, rdata0_d;
        logic [WIDTH-1:0] rdata1_q, rdata1_d;
        logic             rvalid_q, rvalid_d;

        // Capture only on accepted reads; otherwise hold the last result.
        always_comb begin
            rdata0_d = rdata0_q;
            rdata1_d = rdata1_q;
            rvalid_d = rd_en;
            if (rd_en) begin
                rdata0_d = rd_comb[0];
                rdata1_d = rd_comb[1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata0_q <= '0;
                rdata1_q <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata0_q <= rdata0_d;
                rdata1_q <= rdata1_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata0 = rdata0_q;
        assign rdata1 = rdata1_q;
        assign rvalid = rvalid_q;
    end else begin : g_comb_out
        assign rdata0 = rd_comb[0];
        assign rdata1 = rd_comb[1];
        assign rvalid = rd_en;
    end

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file: two reg_file instances share one stimulus stream.
//   dut_c: DEPTH=24, ZERO_REG=1, REG_OUT=0 (combinational read)
//   dut_r: DEPTH=24, ZERO_REG=0, REG_OUT=1 (registered read)
// A behavioural array model tracks both; outputs are compared every negedge.
// ----------------------------------------------------------------------------
module tb_reg_file;
    localparam int W = 32;
    localparam int D = 24;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          rd_en;
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;

    logic [W-1:0] c_d0, c_d1, r_d0, r_d1;
    logic         c_rv, c_err, r_rv, r_err;

    reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .REG_OUT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(c_d0), .rdata1(c_d1), .rvalid(c_rv), .wr_err(c_err)
    );

    reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0), .REG_OUT(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(r_d0), .rdata1(r_d1), .rvalid(r_rv), .wr_err(r_err)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mem_z [D];   // ZERO_REG=1 view
    logic [W-1:0] mem_n [D];   // ZERO_REG=0 view
    logic [W-1:0] exp_r_d0, exp_r_d1;
    logic         exp_r_rv;
    logic         exp_err;

    function automatic logic [W-1:0] ref_read(input bit zr, input logic [AW-1:0] a);
        if (int'(a) >= D) return '0;
        if (zr && a == 0) return '0;
        if (we && int'(waddr) < D && !(zr && waddr == 0) && a == waddr) return wdata;
        return zr ? mem_z[a] : mem_n[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_z[i] = '0;
                mem_n[i] = '0;
            end
            exp_r_d0 = '0;
            exp_r_d1 = '0;
            exp_r_rv = 1'b0;
            exp_err  = 1'b0;
        end else begin
            if (rd_en) begin
                exp_r_d0 = ref_read(1'b0, raddr0);
                exp_r_d1 = ref_read(1'b0, raddr1);
            end
            exp_r_rv = rd_en;
            exp_err  = we && (int'(waddr) >= D);
            if (we && int'(waddr) < D) begin
                mem_n[waddr] = wdata;
                if (waddr != 0) mem_z[waddr] = wdata;
            end
        end
    end

    // Every-cycle compare process.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("c_rdata0", c_d0, ref_read(1'b1, raddr0));
            chk("c_rdata1", c_d1, ref_read(1'b1, raddr1));
            chk("c_rvalid", 32'(c_rv), 32'(rd_en));
            chk("c_wr_err", 32'(c_err), 32'(exp_err));
            chk("r_rdata0", r_d0, exp_r_d0);
            chk("r_rdata1", r_d1, exp_r_d1);
            chk("r_rvalid", 32'(r_rv), 32'(exp_r_rv));
            chk("r_wr_err", 32'(r_err), 32'(exp_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        we = w; waddr = wa; wdata = wd; rd_en = re; raddr0 = a0; raddr1 = a1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c_d0"}, c_d0, '0);
        chk({tag, "_c_d1"}, c_d1, '0);
        chk({tag, "_c_rv"}, 32'(c_rv), '0);
        chk({tag, "_c_err"}, 32'(c_err), '0);
        chk({tag, "_r_d0"}, r_d0, '0);
        chk({tag, "_r_d1"}, r_d1, '0);
        chk({tag, "_r_rv"}, 32'(r_rv), '0);
        chk({tag, "_r_err"}, 32'(r_err), '0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Every register reads zero after reset.
        for (int a = 0; a < D; a++) begin
            step();
            drive(1'b0, '0, '0, 1'b1, AW'(a), AW'(D - 1 - a));
            @(negedge clk);
            chk("init_rd0", c_d0, 32'h0);
            chk("init_rd1", c_d1, 32'h0);
        end

        // Write then read on both ports, then same-cycle bypass.
        step(); drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        step(); drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
        @(negedge clk);
        chk("rd5_p0", c_d0, 32'hDEADBEEF);
        chk("rd5_p1", c_d1, 32'hDEADBEEF);
        step(); drive(1'b1, 5'd7, 32'h1234, 1'b1, 5'd5, 5'd7);
        @(negedge clk);
        chk("bypass_c_p1", c_d1, 32'h1234);
        chk("r_rd5_p0", r_d0, 32'hDEADBEEF);
        chk("r_rv_hi", 32'(r_rv), 32'd1);
        step(); drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd7);
        @(negedge clk);
        chk("bypass_r_p1", r_d1, 32'h1234);

        // Register 0: hardwired in dut_c, ordinary in dut_r.
        step(); drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        @(negedge clk);
        chk("zr_bypass_blocked", c_d0, 32'h0);
        step(); drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
        @(negedge clk);
        chk("zr_c_rd0", c_d0, 32'h0);
        chk("zr_c_err", 32'(c_err), 32'd0);
        chk("nz_r_rd0", r_d0, 32'hFFFFFFFF);

        // Out-of-range write.
        step(); drive(1'b1, 5'd30, 32'hAA, 1'b1, 5'd30, 5'd23);
        @(negedge clk);
        chk("oor_no_bypass", c_d0, 32'h0);
        step(); drive(1'b0, '0, '0, 1'b1, 5'd30, 5'd5);
        @(negedge clk);
        chk("oor_err_c", 32'(c_err), 32'd1);
        chk("oor_err_r", 32'(r_err), 32'd1);
        chk("oor_rd30", c_d0, 32'h0);
        chk("oor_reg5_kept", c_d1, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("oor_err_pulse", 32'(c_err), 32'd0);

        // Registered read latency and hold.
        step(); drive(1'b1, 5'd3, 32'h55, 1'b0, '0, '0);
        step(); drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd3);
        @(negedge clk);
        chk("ro_N_rv", 32'(r_rv), 32'd0);
        step(); drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd5);
        @(negedge clk);
        chk("ro_N1_rv", 32'(r_rv), 32'd1);
        chk("ro_N1_d0", r_d0, 32'h55);
        step();
        @(negedge clk);
        chk("ro_N2_rv", 32'(r_rv), 32'd0);
        chk("ro_N2_d0", r_d0, 32'h55);

        // Reset asserted mid-cycle after a write.
        step(); drive(1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9);
        step(); drive(1'b0, '0, '0, 1'b0, 5'd9, 5'd9);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(); drive(1'b0, '0, '0, 1'b1, 5'd9, 5'd9);
        @(negedge clk);
        chk("post_rst_reg9", c_d0, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] wa;
            step();
            wa = AW'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)));
        end

        step(); drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width of every register and port.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers, legal range 2..256.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 hardwired to zero when 1.
REQ-004 The block SHALL have parameter REG_OUT, default 0, meaning 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-005 The block SHALL derive local ADDR_W = clog2(DEPTH), minimum 1.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock, rising-edge active.
REQ-007 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-008 The block SHALL have port we, input, 1, meaning write enable.
REQ-009 The block SHALL have port waddr, input, ADDR_W, meaning write address.
REQ-010 The block SHALL have port wdata, input, WIDTH, meaning write data.
REQ-011 The block SHALL have port rd_en, input, 1, meaning read request qualifier for both read ports.
REQ-012 The block SHALL have ports raddr0 and raddr1, input, ADDR_W each, meaning read addresses for port 0 and port 1.
REQ-013 The block SHALL have ports rdata0 and rdata1, output, WIDTH each, meaning read data for port 0 and port 1.
REQ-014 The block SHALL have port rvalid, output, 1, meaning rdata0/rdata1 hold data for an accepted rd_en.
REQ-015 The block SHALL have port wr_err, output, 1, meaning a write was dropped because waddr >= DEPTH, pulsed for 1 cycle.

Function
REQ-016 The block SHALL write wdata into register waddr on the rising clk edge when we=1, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0).
REQ-017 The block SHALL ignore writes with waddr>=DEPTH, leave all registers unchanged, and register wr_err=1 for the following cycle only.
REQ-018 The block SHALL ignore writes to register 0 when ZERO_REG=1, with wr_err staying 0.
REQ-019 The block SHALL return 0 on any read port whose address is >= DEPTH, or is 0 with ZERO_REG=1.
REQ-020 The block SHALL bypass wdata to a read port when we=1 and raddrN==waddr in the same cycle, provided the write is legal per REQ-016.
REQ-021 The block SHALL, when REG_OUT=0, drive rdataN combinationally from the array plus bypass, and drive rvalid=rd_en combinationally.
REQ-022 The block SHALL, when REG_OUT=1, sample the read result including bypass on the clk edge where rd_en=1, present it on rdataN from the next cycle, and set rvalid=1 for exactly that one cycle per accepted rd_en.
REQ-023 The block SHALL, when REG_OUT=1 and rd_en=0, hold rdataN at their last values and drive rvalid=0.
REQ-024 The block SHALL serve both read ports independently, with the same address on both ports and simultaneous read of the write target both legal.
REQ-025 The block SHALL give every read made in a cycle after a legal write (we=1) the newly written value.

Reset
REQ-026 The block SHALL, while rst_n=0, asynchronously clear all registers to 0, and clear rvalid, wr_err, and (REG_OUT=1) rdata0/rdata1 to 0.
REQ-027 The block SHALL drop a write coinciding with reset assertion, with no register left holding a partial value.
REQ-028 The block SHALL accept the first write and read on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Reset then REG_OUT=0, read all addresses 0..DEPTH-1 -> rdata0=rdata1=0 for every address.
REQ-030 REG_OUT=0: write 0xDEADBEEF to reg 5; next cycle raddr0=5, raddr1=5 -> both ports return 0xDEADBEEF; same-cycle we=1 waddr=7 wdata=0x1234 with raddr1=7 -> rdata1=0x1234 via bypass.
REQ-031 ZERO_REG=1: write 0xFFFFFFFF to reg 0 -> reads of reg 0 return 0, wr_err=0; ZERO_REG=0 -> reads of reg 0 return 0xFFFFFFFF.
REQ-032 DEPTH=24: write 0xAA to waddr=30 -> wr_err=1 for one cycle, reg 30 reads 0, regs 0..23 unchanged.
REQ-033 REG_OUT=1: rd_en=1 with raddr0=3 (holding 0x55) in cycle N -> rvalid=1 and rdata0=0x55 in cycle N+1; rd_en=0 in N+1 -> rvalid=0 in N+2 with rdata0 still 0x55.
REQ-034 Write 0x77 to reg 9, then assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, reg 9 reads 0.
